vga_fb_reader: RTL and testbench

Frame-buffer read scheduler for the VGA display path. It issues fixed-length burst read requests to the frame-buffer memory port and buffers the returned RGB565 words in an internal FIFO. It then serves them to the VGA output stage through that stage's `data_req`/`pixel_data` pair. Each frame is restarted from `BASE_ADDR` on the rising edge of vertical sync.

---
 rtl/vga_fb_reader_if.sv | 32 +++
 rtl/vga_fb_reader.sv | 174 +++++++++++++++++
 tb/tb_vga_fb_reader.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_fb_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_fb_reader_if
// Description : Memory burst-read port plus VGA pixel port of the frame-buffer
//               reader.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_fb_reader_if #(
    parameter int ADDR_W = 21
) ();
    logic              vsync;
    logic              data_req;
    logic [15:0]       pixel_data;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic              rd_valid;
    logic [15:0]       rd_data;
    logic              underflow;
    logic              frame_done;

    modport master (
        input  vsync, data_req, rd_ack, rd_valid, rd_data,
        output pixel_data, rd_req, rd_addr, underflow, frame_done
    );

    modport slave (
        output vsync, data_req, rd_ack, rd_valid, rd_data,
        input  pixel_data, rd_req, rd_addr, underflow, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/vga_fb_reader.sv
`default_nettype none
// ============================================================================
// Module      : vga_fb_reader
// Description : Burst-reads a frame buffer into a FWFT FIFO that feeds the VGA
//               output stage; restarts the frame on each vsync rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_fb_reader #(
    parameter int          ADDR_W     = 21,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int          H_ACT      = 640,
    parameter int          V_ACT      = 480,
    parameter int          BURST_LEN  = 32,
    parameter int          FIFO_DEPTH = 128
) (
    input  logic            clk,
    input  logic            rst,
    vga_fb_reader_if.master bus
);
    localparam int TOTAL_BURSTS = (H_ACT * V_ACT) / BURST_LEN;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_W        = PTR_W + 1;
    localparam int BEAT_W       = $clog2(BURST_LEN + 1);
    localparam int BRST_W       = $clog2(TOTAL_BURSTS + 1);

    localparam logic [CNT_W-1:0]  SPACE_LIMIT = CNT_W'(FIFO_DEPTH - BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
    localparam logic [BRST_W-1:0] BURSTS_INIT = BRST_W'(TOTAL_BURSTS);
    localparam logic [ADDR_W-1:0] ADDR_BASE   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_STEP   = ADDR_W'(BURST_LEN);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FLUSH = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_REQ   = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;

    logic [2:0]        state;
    logic              vsync_q;
    logic              restart_pend;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_req_q;
    logic [BRST_W-1:0] bursts_left;
    logic [BEAT_W-1:0] beat_cnt;
    logic              frame_done_q;
    logic              underflow_q;

    logic [15:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic vs_rise;
    logic restart;
    logic push;
    logic pop;
    logic fifo_empty;

    assign vs_rise    = bus.vsync & ~vsync_q;
    // Same-cycle vs_rise is honoured so FLUSH lands one cycle after the edge.
    assign restart    = restart_pend | vs_rise;
    assign fifo_empty = (count == '0);
    assign push       = (state == S_DATA) && bus.rd_valid;
    assign pop        = bus.data_req && !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            vsync_q      <= 1'b0;
            restart_pend <= 1'b0;
            next_addr    <= ADDR_BASE;
            rd_addr_q    <= ADDR_BASE;
            rd_req_q     <= 1'b0;
            bursts_left  <= '0;
            beat_cnt     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            vsync_q      <= bus.vsync;
            frame_done_q <= 1'b0;
            if (vs_rise) begin
                restart_pend <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (restart) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    next_addr    <= ADDR_BASE;
                    bursts_left  <= BURSTS_INIT;
                    restart_pend <= vs_rise;
                    state        <= S_CHECK;
                end
                S_CHECK: begin
                    if (restart) begin
                        state <= S_FLUSH;
                    end else if ((bursts_left != '0) && (count <= SPACE_LIMIT)) begin
                        state     <= S_REQ;
                        rd_req_q  <= 1'b1;
                        rd_addr_q <= next_addr;
                    end
                end
                S_REQ: begin
                    // The request is held through any restart until memory accepts it.
                    if (bus.rd_ack) begin
                        rd_req_q <= 1'b0;
                        beat_cnt <= '0;
                        state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bus.rd_valid) begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                        if (beat_cnt == LAST_BEAT) begin
                            next_addr    <= next_addr + ADDR_STEP;
                            bursts_left  <= bursts_left - BRST_W'(1);
                            frame_done_q <= (bursts_left == BRST_W'(1));
                            state        <= S_CHECK;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.data_req && fifo_empty) begin
                underflow_q <= 1'b1;
            end
            if (state == S_FLUSH) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (!push && pop) begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.rd_data;
        end
    end

    assign bus.pixel_data = fifo_empty ? 16'h0000 : mem[rd_ptr];
    assign bus.rd_req     = rd_req_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.underflow  = underflow_q;
    assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_fb_reader
// Description : Scoreboard bench for vga_fb_reader with a burst memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_fb_reader;
    localparam int ADDR_W     = 21;
    localparam int BASE_ADDR  = 0;
    localparam int H_ACT      = 64;
    localparam int V_ACT      = 16;
    localparam int BURST_LEN  = 32;
    localparam int FIFO_DEPTH = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vga_fb_reader_if #(.ADDR_W(ADDR_W)) bus ();

    vga_fb_reader #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .H_ACT     (H_ACT),
        .V_ACT     (V_ACT),
        .BURST_LEN (BURST_LEN),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int                vec_cnt = 0;
    int                err_cnt = 0;
    logic [15:0]       sb [$];
    logic [ADDR_W-1:0] req_addrs [$];
    logic              mem_hold = 1'b0;
    logic              mem_busy = 1'b0;
    int                beat_idx = 0;
    int                fd_cnt = 0;
    logic              fd_prev = 1'b0;
    logic              fd_double = 1'b0;
    logic              ovf_seen = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pop_chk(input string tag);
        logic [15:0] e;
        if (sb.size() != 0) e = sb.pop_front();
        else                e = 16'hdead;
        check(tag, 32'(bus.pixel_data), 32'(e));
    endtask

    task automatic pop_n(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            bus.data_req = 1'b1;
            pop_chk(tag);
            step();
        end
        bus.data_req = 1'b0;
    endtask

    task automatic wait_full();
        int t = 0;
        while (!(dut.count == 8'(FIFO_DEPTH) && !bus.rd_req && !mem_busy) && t < 3000) begin
            step();
            t++;
        end
        check("wait_full", 32'(t < 3000), 32'd1);
    endtask

    task automatic pulse_vsync();
        bus.vsync = 1'b1;
        repeat (4) step();
        bus.vsync = 1'b0;
        step();
    endtask

    // Memory: ack 3 cycles after seeing a request, then one ramp beat per cycle.
    initial begin : mem_model
        logic [ADDR_W-1:0] a;
        bus.rd_ack   = 1'b0;
        bus.rd_valid = 1'b0;
        bus.rd_data  = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (bus.rd_req && !mem_hold && !rst) begin
                mem_busy = 1'b1;
                a = bus.rd_addr;
                req_addrs.push_back(a);
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
                bus.rd_ack = 1'b1;
                @(posedge clk);
                #1;
                bus.rd_ack = 1'b0;
                check("req_drop", 32'(bus.rd_req), 32'd0);
                for (int b = 0; b < BURST_LEN; b++) begin
                    bus.rd_valid = 1'b1;
                    bus.rd_data  = 16'(a + ADDR_W'(b));
                    beat_idx     = b;
                    sb.push_back(16'(a + ADDR_W'(b)));
                    @(posedge clk);
                    #1;
                end
                bus.rd_valid = 1'b0;
                mem_busy     = 1'b0;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (bus.frame_done) begin
                fd_cnt++;
                if (fd_prev) fd_double = 1'b1;
            end
            fd_prev = bus.frame_done;
            if (dut.count > 8'(FIFO_DEPTH)) ovf_seen = 1'b1;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t;
        bus.vsync    = 1'b0;
        bus.data_req = 1'b0;
        rst          = 1'b1;
        repeat (3) step();
        check("rst_rd_req", 32'(bus.rd_req), 32'd0);
        check("rst_rd_addr", 32'(bus.rd_addr), 32'(BASE_ADDR));
        check("rst_underflow", 32'(bus.underflow), 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        check("rst_pixel", 32'(bus.pixel_data), 32'd0);
        rst = 1'b0;
        step();

        // Basic fill, including vsync-to-request latency
        bus.vsync = 1'b1;
        step();
        step();
        check("lat_n2", 32'(bus.rd_req), 32'd0);
        step();
        check("lat_n3", 32'(bus.rd_req), 32'd1);
        bus.vsync = 1'b0;
        wait_full();
        repeat (20) step();
        check("fill_req_low", 32'(bus.rd_req), 32'd0);
        check("fill_count", 32'(dut.count), 32'd128);
        check("fill_nreq", 32'(req_addrs.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("fill_addr", (i < req_addrs.size()) ? 32'(req_addrs[i]) : 32'hffffffff,
                  32'(BASE_ADDR + i * BURST_LEN));
        end

        // Streaming the whole frame with VGA-like line timing
        for (int ln = 0; ln < V_ACT; ln++) begin
            pop_n(H_ACT, "stream_px");
            repeat (32) step();
        end
        check("stream_underflow", 32'(bus.underflow), 32'd0);
        check("stream_frame_done", 32'(fd_cnt), 32'd1);
        check("stream_nreq", 32'(req_addrs.size()), 32'd32);
        check("stream_last_addr", (req_addrs.size() == 32) ? 32'(req_addrs[31]) : 32'hffffffff, 32'd992);
        check("stream_sb_left", 32'(sb.size()), 32'd0);

        // Simultaneous push/pop at count 96, across pointer wrap
        sb.delete();
        req_addrs.delete();
        pulse_vsync();
        wait_full();
        mem_hold = 1'b1;
        pop_n(32, "pp_pre_px");
        repeat (4) step();
        check("pp_count96", 32'(dut.count), 32'd96);
        check("pp_req_held", 32'(bus.rd_req), 32'd1);
        mem_hold = 1'b0;
        t = 0;
        while (!bus.rd_ack && t < 50) begin
            step();
            t++;
        end
        check("pp_ack_seen", 32'(bus.rd_ack), 32'd1);
        step();
        for (int i = 0; i < 32; i++) begin
            bus.data_req = 1'b1;
            check("pp_count", 32'(dut.count), 32'd96);
            pop_chk("pp_px");
            step();
        end
        bus.data_req = 1'b0;
        check("pp_count_end", 32'(dut.count), 32'd96);

        // vsync rising at beat 10 of a burst
        t = 0;
        while (!(bus.rd_valid && beat_idx == 10) && t < 100) begin
            step();
            t++;
        end
        check("rs_beat10", 32'(beat_idx), 32'd10);
        bus.vsync = 1'b1;
        t = 0;
        while (bus.rd_valid && t < 100) begin
            step();
            t++;
        end
        bus.vsync = 1'b0;
        check("rs_all_beats", 32'(dut.count), 32'd128);
        sb.delete();
        req_addrs.delete();
        step();
        step();
        check("rs_flushed", 32'(dut.count), 32'd0);
        t = 0;
        while (req_addrs.size() == 0 && t < 50) begin
            step();
            t++;
        end
        check("rs_addr", (req_addrs.size() != 0) ? 32'(req_addrs[0]) : 32'hffffffff, 32'(BASE_ADDR));
        wait_full();
        pop_n(4, "rs_px");

        // Underflow on an empty FIFO, sticky across frames
        mem_hold = 1'b1;
        pulse_vsync();
        sb.delete();
        check("uf_empty", 32'(dut.count), 32'd0);
        check("uf_pre", 32'(bus.underflow), 32'd0);
        for (int i = 0; i < 5; i++) begin
            bus.data_req = 1'b1;
            check("uf_px", 32'(bus.pixel_data), 32'd0);
            step();
        end
        bus.data_req = 1'b0;
        check("uf_set", 32'(bus.underflow), 32'd1);
        pulse_vsync();
        mem_hold = 1'b0;
        wait_full();
        check("uf_sticky", 32'(bus.underflow), 32'd1);

        // Reset while a request waits for rd_ack
        mem_hold = 1'b1;
        pulse_vsync();
        check("rr_req_held", 32'(bus.rd_req), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rr_req_low", 32'(bus.rd_req), 32'd0);
        check("rr_uf_clr", 32'(bus.underflow), 32'd0);
        check("rr_count", 32'(dut.count), 32'd0);
        repeat (20) step();
        check("rr_idle", 32'(bus.rd_req), 32'd0);
        mem_hold = 1'b0;
        sb.delete();
        req_addrs.delete();
        bus.vsync = 1'b1;
        step();
        step();
        check("rr_lat2", 32'(bus.rd_req), 32'd0);
        step();
        check("rr_lat3", 32'(bus.rd_req), 32'd1);
        bus.vsync = 1'b0;
        wait_full();
        pop_n(8, "rr_px");

        check("no_overflow", 32'(ovf_seen), 32'd0);
        check("frame_done_single", 32'(fd_double), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
`default_nettype wire
